// File: rtl/vga_pkg.sv
// Shared VGA timing constants, readback FSM encoding
// and the per-pixel context carried down the fetch pipe.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_RESP  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic       active;
    logic [2:0] col;
    logic [3:0] vline;
  } pix_ctx_t;

endpackage

// File: rtl/vga_pipe_dly.sv
// Two-stage register delay line for the pixel context
// that travels alongside the text and font RAM reads.
module vga_pipe_dly #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d1_o,
  output logic [W-1:0] d2_o
);

  logic [W-1:0] d1_q;
  logic [W-1:0] d2_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= d_i;
      d2_q <= d1_q;
    end
  end

  assign d1_o = d1_q;
  assign d2_o = d2_q;

endmodule

// File: rtl/vga_font_ctrl.sv
// Text-mode glyph fetch and pixel shifter with a host
// font readback port that only uses blanking cycles.
module vga_font_ctrl #(
  parameter int FONT_ADDR_WIDTH = 11,
  parameter int FONT_DATA_WIDTH = 8,
  parameter int TEXT_COLS       = 80
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [9:0]                 hcount_i,
  input  logic [9:0]                 vcount_i,
  input  logic                       active_i,
  output logic [11:0]                char_addr_o,
  input  logic [6:0]                 char_i,
  output logic [FONT_ADDR_WIDTH-1:0] font_addr_o,
  input  logic [FONT_DATA_WIDTH-1:0] font_data_i,
  output logic                       pixel_o,
  output logic                       pixel_valid_o,
  input  logic                       rd_req_i,
  input  logic [FONT_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                       rd_ack_o,
  output logic [FONT_DATA_WIDTH-1:0] rd_data_o
);

  import vga_pkg::*;

  pix_ctx_t ctx_in;
  pix_ctx_t ctx_d1;
  pix_ctx_t ctx_d2;

  rd_state_e                  state_q;
  logic [FONT_ADDR_WIDTH-1:0] addr_q;
  logic                       ack_q;
  logic [FONT_DATA_WIDTH-1:0] data_q;

  logic pix_d;
  logic pix_q;
  logic pixv_d;
  logic pixv_q;

  assign ctx_in = '{
    active: active_i,
    col:    hcount_i[2:0],
    vline:  vcount_i[3:0]
  };

  vga_pipe_dly #(
    .W ($bits(pix_ctx_t))
  ) u_dly (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (ctx_in),
    .d1_o   (ctx_d1),
    .d2_o   (ctx_d2)
  );

  always_comb begin
    char_addr_o = '0;
    if (active_i)
      char_addr_o = 12'(vcount_i[9:4]) * 12'(TEXT_COLS)
                  + 12'(hcount_i[9:3]);
  end

  // ISSUE only ever lands on a cycle whose stage-1 slot is blank
  always_comb begin
    font_addr_o = FONT_ADDR_WIDTH'({char_i, ctx_d1.vline});
    if (state_q == RD_ISSUE)
      font_addr_o = addr_q;
  end

  always_comb begin
    pix_d  = ctx_d2.active ? font_data_i[ctx_d2.col] : 1'b0;
    pixv_d = ctx_d2.active;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pix_q  <= 1'b0;
      pixv_q <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      pixv_q <= pixv_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        RD_IDLE: begin
          if (rd_req_i && !active_i) begin
            state_q <= RD_ISSUE;
            addr_q  <= rd_addr_i;
          end
        end
        RD_ISSUE: state_q <= RD_RESP;
        RD_RESP: begin
          data_q  <= font_data_i;
          ack_q   <= 1'b1;
          state_q <= RD_IDLE;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign pixel_o       = pix_q;
  assign pixel_valid_o = pixv_q;
  assign rd_ack_o      = ack_q;
  assign rd_data_o     = data_q;

endmodule
